// File: rtl/pwm_servo_pkg.sv
// Shared constants and the per-frame slew helper for the servo PWM array.
// Duty arithmetic runs at 64 bits so any WIDTH up to 64 can reuse it.
package pwm_servo_pkg;

  localparam int unsigned DEF_PERIOD_C = 2000;
  localparam int unsigned DEF_DUTY_C   = 150;

  typedef logic [63:0] duty_t;

  // One frame's move of the active duty toward its target, at most step
  // per frame; step == 0 jumps straight to the target.
  function automatic duty_t next_duty(duty_t active, duty_t target, duty_t step);
    duty_t diff;
    diff = (target >= active) ? (target - active) : (active - target);
    if (step == '0 || diff <= step) begin
      return target;
    end else if (target > active) begin
      return active + step;
    end else begin
      return active - step;
    end
  endfunction

endpackage

// File: rtl/pwm_servo_channel.sv
// One PWM channel: duty target register, frame-committed active duty,
// registered compare output and busy flag.
module pwm_servo_channel
  import pwm_servo_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEF_DUTY = DEF_DUTY_C,
  parameter int unsigned STEP     = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wrap,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm,
  output logic             busy
);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;

  // The wrap update reads target_q, so a write landing on the wrap edge
  // is only picked up at the following wrap.
  always_comb begin
    target_d = target_q;
    if (wr_en) begin
      target_d = wr_duty;
    end
    active_d = active_q;
    if (wrap) begin
      active_d = WIDTH'(next_duty(64'(active_q), 64'(target_q), 64'(STEP)));
    end
    pwm_d = (cnt < active_q);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      target_q <= WIDTH'(DEF_DUTY);
      active_q <= WIDTH'(DEF_DUTY);
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign busy = (active_q != target_q);

endmodule

// File: rtl/pwm_servo_array.sv
// Multi-channel servo PWM generator: one shared frame counter, per-channel
// duty targets committed only at frame boundaries.
module pwm_servo_array
  import pwm_servo_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter int unsigned DEF_DUTY   = DEF_DUTY_C,
  parameter int unsigned STEP       = 0,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                res,
  input  logic [WIDTH-1:0]    t,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic                wr_err,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_start,
  output logic [CHANNELS-1:0] busy
);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic                frame_start_q, frame_start_d;
  logic                wr_err_q, wr_err_d;
  logic                wrap;
  logic                wr_valid;
  logic [CHANNELS-1:0] ch_wr;

  // Periods below 2 are clamped so the counter always has a distinct wrap.
  always_comb begin
    wrap          = (cnt_q == period_q - WIDTH'(1));
    cnt_d         = wrap ? '0 : cnt_q + WIDTH'(1);
    period_d      = period_q;
    if (wrap) begin
      period_d = (t < WIDTH'(2)) ? WIDTH'(2) : t;
    end
    frame_start_d = wrap;
    wr_valid      = wr_en && (32'(wr_ch) < CHANNELS);
    wr_err_d      = wr_en && !wr_valid;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q         <= '0;
      period_q      <= WIDTH'(DEF_PERIOD);
      frame_start_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      frame_start_q <= frame_start_d;
      wr_err_q      <= wr_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch_wr[gi] = wr_valid && (wr_ch == CH_W'(gi));

      pwm_servo_channel #(
        .WIDTH   (WIDTH),
        .DEF_DUTY(DEF_DUTY),
        .STEP    (STEP)
      ) u_ch (
        .clk    (clk),
        .res    (res),
        .wrap   (wrap),
        .wr_en  (ch_wr[gi]),
        .wr_duty(wr_duty),
        .cnt    (cnt_q),
        .pwm    (pwm[gi]),
        .busy   (busy[gi])
      );
    end
  endgenerate

  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pwm_servo_array.sv
// Bench for pwm_servo_array: an immediate-jump and a slew-limited instance
// share stimulus; per-frame high times are scored against a frame model.
module tb_pwm_servo_array;
  localparam int NCH   = 3;
  localparam int W     = 32;
  localparam int SSTEP = 10;
  localparam int BOUND = 5000;

  logic           clk = 1'b0;
  logic           res = 1'b1;
  logic [W-1:0]   t = 2000;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [W-1:0]   wr_duty = '0;
  logic           wr_err_j, wr_err_s, fs_j, fs_s;
  logic [NCH-1:0] pwm_j, pwm_s, busy_j, busy_s;

  always #5 clk = ~clk;

  pwm_servo_array #(.CHANNELS(NCH), .WIDTH(W), .DEF_PERIOD(2000), .DEF_DUTY(150), .STEP(0)) dut_j (
    .clk(clk), .res(res), .t(t), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .wr_err(wr_err_j), .pwm(pwm_j), .frame_start(fs_j), .busy(busy_j));

  pwm_servo_array #(.CHANNELS(NCH), .WIDTH(W), .DEF_PERIOD(2000), .DEF_DUTY(150), .STEP(SSTEP)) dut_s (
    .clk(clk), .res(res), .t(t), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .wr_err(wr_err_s), .pwm(pwm_s), .frame_start(fs_s), .busy(busy_s));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected frame: length and per-channel high time for both instances.
  typedef struct packed {
    logic [15:0]          len;
    logic [NCH-1:0][15:0] hj;
    logic [NCH-1:0][15:0] hs;
  } frame_t;
  frame_t sb_q[$];

  typedef struct {
    logic [1:0]     ch;
    int             duty;
    bit             err;
    logic [NCH-1:0] busy;
  } wvec_t;
  wvec_t wv[5];
  bit    rb[4];

  // Frame-level reference state.
  int tgt[NCH], act_j[NCH], act_s[NCH];
  int t_cur, per;

  function automatic int nxt(input int a, input int tg, input int s);
    int d;
    d = (tg > a) ? tg - a : a - tg;
    if (s == 0 || d <= s) return tg;
    return (tg > a) ? a + s : a - s;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      tgt[c] = 150; act_j[c] = 150; act_s[c] = 150;
    end
    per = 2000;
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fs_j && n < BOUND);
    if (!fs_j) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_wait: no frame_start within %0d cycles", BOUND);
    end
  endtask

  // Called in the cnt==0 cycle of a new frame: advance the model, push expectation.
  task automatic frame_begun();
    frame_t f;
    check("fs_j", fs_j, 1);
    check("fs_s", fs_s, 1);
    per = (t_cur < 2) ? 2 : t_cur;
    f.len = 16'(per);
    for (int c = 0; c < NCH; c++) begin
      act_j[c] = nxt(act_j[c], tgt[c], 0);
      act_s[c] = nxt(act_s[c], tgt[c], SSTEP);
      f.hj[c]  = 16'(min2(act_j[c], per));
      f.hs[c]  = 16'(min2(act_s[c], per));
    end
    sb_q.push_back(f);
    $display("frame: len=%0d act_j=%0d/%0d/%0d act_s=%0d/%0d/%0d", per,
             act_j[0], act_j[1], act_j[2], act_s[0], act_s[1], act_s[2]);
  endtask

  task automatic start_frame();
    int n;
    wait_fs(n);
    frame_begun();
  endtask

  task automatic do_write(input logic [1:0] ch, input int d);
    wr_ch = ch; wr_duty = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    $display("write: ch=%0d duty=%0d wr_err=%0b busy_j=%b busy_s=%b", ch, d, wr_err_j, busy_j, busy_s);
  endtask

  // Frame monitor: counts pwm highs from after one frame_start through the next.
  int     m_len;
  int     m_hj[NCH], m_hs[NCH];
  bit     armed = 1'b0;
  frame_t mf;

  always @(negedge clk) begin
    if (res) begin
      armed = 1'b0;
    end else begin
      if (armed) begin
        m_len++;
        for (int c = 0; c < NCH; c++) begin
          m_hj[c] += int'(pwm_j[c]);
          m_hs[c] += int'(pwm_s[c]);
        end
      end
      if (fs_j) begin
        if (armed) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_empty: frame of %0d cycles with no expectation", m_len);
          end else begin
            mf = sb_q.pop_front();
            check("frame_len", m_len, mf.len);
            for (int c = 0; c < NCH; c++) begin
              check($sformatf("high_j%0d", c), m_hj[c], mf.hj[c]);
              check($sformatf("high_s%0d", c), m_hs[c], mf.hs[c]);
            end
          end
        end
        m_len = 0;
        for (int c = 0; c < NCH; c++) begin m_hj[c] = 0; m_hs[c] = 0; end
        armed = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wv[0] = '{2'd1, 200,  1'b0, 3'b010};
    wv[1] = '{2'd3, 777,  1'b1, 3'b010};
    wv[2] = '{2'd2, 2500, 1'b0, 3'b110};
    wv[3] = '{2'd0, 90,   1'b0, 3'b111};
    wv[4] = '{2'd0, 150,  1'b0, 3'b110};
    rb    = '{1'b1, 1'b1, 1'b1, 1'b0};
    model_reset();
    t_cur = 2000;

    repeat (100) @(posedge clk);
    #1;
    check("rst_pwm_j", pwm_j, 0);
    check("rst_pwm_s", pwm_s, 0);
    check("rst_fs", fs_j, 0);
    check("rst_err", wr_err_j, 0);
    check("rst_busy_j", busy_j, 0);
    check("rst_busy_s", busy_s, 0);
    res = 1'b0;

    wait_fs(n);
    check("first_frame_cycles", n, 2000);
    frame_begun();

    // Mid-frame writes at cnt=500: targets move, active waits for the wrap.
    cycles(500);
    for (int i = 0; i < 5; i++) begin
      do_write(wv[i].ch, wv[i].duty);
      check($sformatf("wv%0d_err", i), wr_err_j, wv[i].err);
      check($sformatf("wv%0d_err_s", i), wr_err_s, wv[i].err);
      check($sformatf("wv%0d_busy_j", i), busy_j, wv[i].busy);
      check($sformatf("wv%0d_busy_s", i), busy_s, wv[i].busy);
      if (!wv[i].err) tgt[wv[i].ch] = wv[i].duty;
    end

    start_frame();
    check("post_wrap_busy_j", busy_j, 3'b000);
    check("post_wrap_busy_s", busy_s, 3'b110);

    // Period change mid-frame only applies from the next wrap.
    cycles(300);
    t = 300; t_cur = 300;
    for (int k = 0; k < 4; k++) begin
      start_frame();
      check($sformatf("ramp_busy_s1_%0d", k), busy_s[1], rb[k]);
    end

    do_write(2'd0, 100); tgt[0] = 100;
    do_write(2'd2, 0);   tgt[2] = 0;
    for (int k = 0; k < 5; k++) start_frame();

    cycles(5);
    t = 1; t_cur = 1;
    repeat (3) start_frame();
    t = 50; t_cur = 50;
    start_frame();

    // Write captured on the wrap edge: that wrap still commits the old target.
    cycles(49);
    do_write(2'd0, 30);
    frame_begun();
    tgt[0] = 30;
    start_frame();
    start_frame();

    // Reset in the middle of a frame with outputs and busy active.
    cycles(10);
    do_write(2'd1, 40);
    check("pre_rst_pwm_j", pwm_j, 3'b011);
    check("pre_rst_busy_j", busy_j, 3'b010);
    res = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_pwm_j", pwm_j, 0);
    check("mid_rst_pwm_s", pwm_s, 0);
    check("mid_rst_fs", fs_j, 0);
    check("mid_rst_busy_j", busy_j, 0);
    check("mid_rst_busy_s", busy_s, 0);
    sb_q.delete();
    model_reset();
    cycles(2);
    res = 1'b0;
    wait_fs(n);
    check("post_rst_frame_cycles", n, 2000);
    frame_begun();
    wait_fs(n);
    @(negedge clk); #1;
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_servo_array.md
Name: pwm_servo_array

Overview:
Multi-channel servo PWM generator and parametrised successor to the single-channel servo PWM block. One shared frame counter drives CHANNELS outputs. Each channel has its own duty target, written through a simple write port. Period and duty changes are committed only at frame boundaries, so pulses are never glitched. An optional per-frame slew limit ramps each channel toward its target. It sits between the cube-solver move sequencer and the servo pins.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
WIDTH, 32, width of the counter, period and duty values
DEF_PERIOD, 2000, period in clk cycles loaded at reset
DEF_DUTY, 150, active and target duty of every channel at reset
STEP, 0, maximum duty change per frame; 0 means an immediate jump to the target

Ports:
clk  in  1  system clock
res  in  1  reset, synchronous, active-high
t  in  WIDTH  requested period in clk cycles; sampled only at frame wrap
wr_en  in  1  one-cycle write strobe
wr_ch  in  $clog2(CHANNELS) (min 1)  channel index for the write
wr_duty  in  WIDTH  new duty target, high time in clk cycles
wr_err  out  1  one-cycle pulse: write with wr_ch >= CHANNELS was ignored
pwm  out  CHANNELS  registered PWM outputs
frame_start  out  1  one-cycle pulse in the first cycle of each frame
busy  out  CHANNELS  busy[i]=1 while active duty of channel i differs from its target

Behaviour:
- Reset (res=1 at a posedge) sets:
  - cnt=0, period_q=DEF_PERIOD
  - target[i]=active[i]=DEF_DUTY
  - pwm=0, frame_start=0, wr_err=0
- Reset overrides writes and wrap in the same cycle. Reset mid-frame abandons the frame; the first frame after reset starts at cnt=0.
- Counter: wrap = (cnt == period_q-1).
  - On wrap, cnt<=0; otherwise cnt<=cnt+1.
- On wrap:
  - period_q <= max(t, 2). t changes mid-frame have no effect until the next wrap.
  - Every active[i] is updated from target[i] using the pre-edge target value:
    - STEP==0: active<=target.
    - |target-active| <= STEP: active<=target.
    - Otherwise: active <= active ± STEP, toward the target.
    - Unsigned arithmetic; no underflow or overflow is possible by construction.
- pwm[i] <= (cnt < active[i]), using pre-edge values. The output therefore lags cnt by one cycle.
  - active >= period_q gives a constant high.
  - active == 0 gives a constant low.
- frame_start <= wrap. It is high in the cycle where cnt==0, except the very first frame after reset.
- Writes:
  - On wr_en with wr_ch < CHANNELS: target[wr_ch] <= wr_duty.
  - On wr_en with wr_ch >= CHANNELS: nothing changes and wr_err <= 1 for one cycle.
  - A write in the same cycle as wrap lands in target but is not seen by that wrap's update; it applies at the next wrap.
  - Back-to-back writes to the same channel: the last one wins.
- busy[i] = (active[i] != target[i]), combinational from registers.
- No handshake back-pressure; the write port always accepts.

Decomposition:
- Package pwm_servo_pkg holds:
  - the default period and duty constants
  - a slew-step function: next_duty(active, target, step)
- Natural sub-module: pwm_servo_channel, one instance per channel. It contains the target and active registers, the slew update on wrap, the compare, the pwm flop and busy.
- The top level holds cnt, period_q, frame_start, write decode and wr_err.

Test Plan:
- Defaults: reset for 100 cycles, release → every pwm[i] is high for exactly 150 cycles out of every 2000; frame_start pulses every 2000 cycles.
- Write ch1 duty=200 at cnt=500 → ch1 stays at 150 for the current frame and is 200 from the next frame; other channels are unchanged; busy[1] is high until the wrap.
- STEP=10, write ch0 duty=200 → successive frames give high times 160,170,180,190,200; busy[0] drops after the 5th wrap. Write duty=100 → 140,130,...,100.
- Boundaries:
  - duty=2500 with period 2000 → constant high.
  - duty=0 → constant low.
  - t=1 → period_q=2.
- Change t from 2000 to 100 at cnt=300 → the current frame still lasts 2000 cycles; subsequent frames last 100.
- wr_ch=CHANNELS → wr_err pulses one cycle and no target changes. A write coincident with wrap takes effect one frame later. res asserted mid-frame → all outputs return to their reset values on the next edge.
